// File: rtl/rv32i_pkg.sv
// Shared RV32I encodings: writeback source select, load funct3 values
// and the writeback FSM state type.
package rv32i_pkg;

    typedef enum logic [1:0] {
        WB_ALU  = 2'd0,
        WB_LOAD = 2'd1,
        WB_PC4  = 2'd2,
        WB_NONE = 2'd3
    } wb_sel_e;

    localparam logic [2:0] LB  = 3'd0;
    localparam logic [2:0] LH  = 3'd1;
    localparam logic [2:0] LW  = 3'd2;
    localparam logic [2:0] LBU = 3'd4;
    localparam logic [2:0] LHU = 3'd5;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_LOAD = 2'd1,
        COMMIT    = 2'd2
    } wb_state_e;

endpackage

// File: rtl/wb_stage_load_align.sv
// Load data extraction: picks the byte/half lane out of an aligned memory
// word, sign/zero-extends it and flags misaligned or illegal load types.
module load_align
    import rv32i_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  addr_i,
    input  logic [31:0] rdata_i,
    output logic [31:0] data_o,
    output logic        misalign_o,
    output logic        illegal_o
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v     = 8'(rdata_i >> {addr_i, 3'b000});
        half_v     = addr_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        data_o     = rdata_i;
        misalign_o = 1'b0;
        illegal_o  = 1'b0;
        case (funct3_i)
            LB:  data_o = {{24{byte_v[7]}}, byte_v};
            LH: begin
                data_o     = {{16{half_v[15]}}, half_v};
                misalign_o = addr_i[0];
            end
            LW:  misalign_o = |addr_i;
            LBU: data_o = {24'd0, byte_v};
            LHU: begin
                data_o     = {16'd0, half_v};
                misalign_o = addr_i[0];
            end
            default: begin
                data_o    = 32'd0;
                illegal_o = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// RV32I writeback stage: registered register-file write port with bypass,
// load-response wait and alignment, and the 64-bit retired counter.
//
// state     | meaning
// IDLE      | no write in flight, ready for a new instruction
// WAIT_LOAD | load accepted, waiting for mem_rvalid_i
// COMMIT    | write-port outputs valid this cycle, may accept next
module wb_stage
    import rv32i_pkg::*;
#(
    parameter int DataWidth = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 valid_i,
    output logic                 ready_o,
    input  logic [4:0]           rd_i,
    input  logic [1:0]           wb_sel_i,
    input  logic [DataWidth-1:0] alu_i,
    input  logic [DataWidth-1:0] pc4_i,
    input  logic [2:0]           funct3_i,
    input  logic                 mem_rvalid_i,
    input  logic [DataWidth-1:0] mem_rdata_i,
    output logic                 wen_o,
    output logic [4:0]           addrWr_o,
    output logic [DataWidth-1:0] data_o,
    output logic                 byp_valid_o,
    output logic [4:0]           byp_rd_o,
    output logic [DataWidth-1:0] byp_data_o,
    output logic                 err_o,
    output logic [63:0]          instret_o
);

    wb_state_e            state_q, state_d;
    logic                 wen_q, wen_d;
    logic [4:0]           rd_q, rd_d;
    logic [DataWidth-1:0] data_q, data_d;
    logic                 err_q, err_d;
    logic [63:0]          instret_q, instret_d;
    logic [4:0]           ld_rd_q, ld_rd_d;
    logic [2:0]           ld_f3_q, ld_f3_d;
    logic [1:0]           ld_addr_q, ld_addr_d;

    logic [31:0] al_data;
    logic        al_misalign;
    logic        al_illegal;
    logic        accept;

    load_align u_load_align (
        .funct3_i   (ld_f3_q),
        .addr_i     (ld_addr_q),
        .rdata_i    (mem_rdata_i),
        .data_o     (al_data),
        .misalign_o (al_misalign),
        .illegal_o  (al_illegal)
    );

    assign ready_o = (state_q != WAIT_LOAD);
    assign accept  = valid_i && ready_o;

    always_comb begin
        state_d   = state_q;
        wen_d     = wen_q;
        rd_d      = rd_q;
        data_d    = data_q;
        err_d     = 1'b0;
        instret_d = instret_q;
        ld_rd_d   = ld_rd_q;
        ld_f3_d   = ld_f3_q;
        ld_addr_d = ld_addr_q;

        if (state_q == WAIT_LOAD) begin
            if (mem_rvalid_i) begin
                state_d = COMMIT;
                rd_d    = ld_rd_q;
                if (al_misalign || al_illegal) begin
                    err_d = 1'b1;
                    wen_d = 1'b0;
                end else begin
                    wen_d     = (ld_rd_q != 5'd0);
                    data_d    = al_data;
                    instret_d = instret_q + 64'd1;
                end
            end
        end else begin
            // IDLE and COMMIT behave alike; COMMIT just had its outputs shown
            state_d = IDLE;
            wen_d   = 1'b0;
            if (accept) begin
                if (wb_sel_i == WB_LOAD) begin
                    state_d   = WAIT_LOAD;
                    ld_rd_d   = rd_i;
                    ld_f3_d   = funct3_i;
                    ld_addr_d = alu_i[1:0];
                end else begin
                    state_d   = COMMIT;
                    rd_d      = rd_i;
                    data_d    = (wb_sel_i == WB_PC4) ? pc4_i : alu_i;
                    wen_d     = (wb_sel_i != WB_NONE) && (rd_i != 5'd0);
                    instret_d = instret_q + 64'd1;
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            wen_q     <= 1'b0;
            rd_q      <= 5'd0;
            data_q    <= '0;
            err_q     <= 1'b0;
            instret_q <= 64'd0;
            ld_rd_q   <= 5'd0;
            ld_f3_q   <= 3'd0;
            ld_addr_q <= 2'd0;
        end else begin
            state_q   <= state_d;
            wen_q     <= wen_d;
            rd_q      <= rd_d;
            data_q    <= data_d;
            err_q     <= err_d;
            instret_q <= instret_d;
            ld_rd_q   <= ld_rd_d;
            ld_f3_q   <= ld_f3_d;
            ld_addr_q <= ld_addr_d;
        end
    end

    assign wen_o       = wen_q;
    assign addrWr_o    = rd_q;
    assign data_o      = data_q;
    assign byp_valid_o = wen_q;
    assign byp_rd_o    = rd_q;
    assign byp_data_o  = data_q;
    assign err_o       = err_q;
    assign instret_o   = instret_q;

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed scenarios plus random traffic
// compared against a transaction-level writeback model.
module tb_wb_stage;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        valid_i;
    logic        ready_o;
    logic [4:0]  rd_i;
    logic [1:0]  wb_sel_i;
    logic [31:0] alu_i;
    logic [31:0] pc4_i;
    logic [2:0]  funct3_i;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;
    logic        wen_o;
    logic [4:0]  addrWr_o;
    logic [31:0] data_o;
    logic        byp_valid_o;
    logic [4:0]  byp_rd_o;
    logic [31:0] byp_data_o;
    logic        err_o;
    logic [63:0] instret_o;

    always #5 clk_i = ~clk_i;

    wb_stage #(.DataWidth(32)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .valid_i      (valid_i),
        .ready_o      (ready_o),
        .rd_i         (rd_i),
        .wb_sel_i     (wb_sel_i),
        .alu_i        (alu_i),
        .pc4_i        (pc4_i),
        .funct3_i     (funct3_i),
        .mem_rvalid_i (mem_rvalid_i),
        .mem_rdata_i  (mem_rdata_i),
        .wen_o        (wen_o),
        .addrWr_o     (addrWr_o),
        .data_o       (data_o),
        .byp_valid_o  (byp_valid_o),
        .byp_rd_o     (byp_rd_o),
        .byp_data_o   (byp_data_o),
        .err_o        (err_o),
        .instret_o    (instret_o)
    );

    int total = 0;
    int bad   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model: one pending load at most, plus the expected write port.
    bit          m_wait;
    logic [4:0]  m_rd;
    logic [2:0]  m_f3;
    logic [1:0]  m_addr;
    bit          e_wen;
    bit          e_err;
    logic [4:0]  e_rd;
    logic [31:0] e_data;
    logic [63:0] e_ret;

    function automatic void load_ref(input logic [2:0] f3, input logic [1:0] a,
                                     input logic [31:0] w,
                                     output logic [31:0] d, output bit err);
        longint unsigned sh;
        longint          v;
        int              size;
        bit              sgn;
        sh = longint'(w) >> (8 * a);
        case (f3)
            3'd0:    begin size = 1; sgn = 1; end
            3'd1:    begin size = 2; sgn = 1; end
            3'd2:    begin size = 4; sgn = 0; end
            3'd4:    begin size = 1; sgn = 0; end
            3'd5:    begin size = 2; sgn = 0; end
            default: begin size = 0; sgn = 0; end
        endcase
        err = (size == 0) || ((int'(a) % (size == 0 ? 1 : size)) != 0);
        if (size == 0 || size == 4) begin
            d = w;
        end else begin
            v = longint'(sh % (64'd1 << (8 * size)));
            if (sgn && v >= (longint'(1) << (8 * size - 1)))
                v = v - (longint'(1) << (8 * size));
            d = 32'(v);
        end
    endfunction

    function automatic void model_reset();
        m_wait = 0; m_rd = 0; m_f3 = 0; m_addr = 0;
        e_wen = 0; e_err = 0; e_rd = 0; e_data = 0; e_ret = 0;
    endfunction

    task automatic set_idle();
        valid_i = 0; rd_i = 0; wb_sel_i = 0; alu_i = 0; pc4_i = 0;
        funct3_i = 0; mem_rvalid_i = 0; mem_rdata_i = 0;
    endtask

    // One clock: drive inputs, check ready, advance model and DUT, check outputs.
    task automatic step(input bit v, input logic [1:0] sel, input logic [4:0] rd,
                        input logic [31:0] alu, input logic [31:0] pc4,
                        input logic [2:0] f3, input bit rv, input logic [31:0] rdata);
        logic [31:0] d;
        bit          lerr;
        valid_i = v; wb_sel_i = sel; rd_i = rd; alu_i = alu; pc4_i = pc4;
        funct3_i = f3; mem_rvalid_i = rv; mem_rdata_i = rdata;
        check_eq("ready", ready_o, !m_wait);
        @(posedge clk_i);
        e_err = 0;
        if (m_wait) begin
            e_wen = 0;
            if (rv) begin
                load_ref(m_f3, m_addr, rdata, d, lerr);
                m_wait = 0;
                e_err  = lerr;
                e_rd   = m_rd;
                if (!lerr) begin
                    e_wen  = (m_rd != 0);
                    e_data = d;
                    e_ret  = e_ret + 1;
                end
            end
        end else begin
            e_wen = 0;
            if (v && sel == 2'd1) begin
                m_wait = 1; m_rd = rd; m_f3 = f3; m_addr = alu[1:0];
            end else if (v) begin
                e_rd   = rd;
                e_data = (sel == 2'd2) ? pc4 : alu;
                e_wen  = (sel != 2'd3) && (rd != 0);
                e_ret  = e_ret + 1;
            end
        end
        #1;
        check_eq("wen", wen_o, e_wen);
        check_eq("byp_valid", byp_valid_o, e_wen);
        check_eq("err", err_o, e_err);
        check_eq("instret", instret_o, e_ret);
        if (e_wen) begin
            check_eq("addrWr", addrWr_o, e_rd);
            check_eq("data", data_o, e_data);
            check_eq("byp_rd", byp_rd_o, e_rd);
            check_eq("byp_data", byp_data_o, e_data);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_wen"}, wen_o, 0);
        check_eq({tag, "_addr"}, addrWr_o, 0);
        check_eq({tag, "_data"}, data_o, 0);
        check_eq({tag, "_err"}, err_o, 0);
        check_eq({tag, "_instret"}, instret_o, 0);
        check_eq({tag, "_ready"}, ready_o, 1);
        check_eq({tag, "_byp"}, {byp_valid_o, byp_rd_o, byp_data_o}, 0);
    endtask

    logic [63:0] ret_save;

    initial begin
        set_idle();
        model_reset();
        rst_i = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;
        check_reset_outputs("rst_init");
        rst_i = 1'b0;

        // Commit something, start a load, then reset asynchronously mid-load.
        step(1, 2'd2, 5'd3, 32'h0, 32'h0000_1004, 3'd0, 0, 32'h0);
        step(1, 2'd1, 5'd4, 32'h0000_2000, 32'h0, 3'd2, 0, 32'h0);
        step(0, 2'd0, 5'd0, 32'h0, 32'h0, 3'd0, 0, 32'h0);
        #2 rst_i = 1'b1;
        #1;
        check_reset_outputs("rst_mid");
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        set_idle();
        model_reset();
        step(0, 2'd0, 5'd0, 32'h0, 32'h0, 3'd0, 1, 32'hDEAD_BEEF);
        step(0, 2'd0, 5'd0, 32'h0, 32'h0, 3'd0, 0, 32'h0);

        // ALU back-to-back
        step(1, 2'd0, 5'd5, 32'h11, 32'h0, 3'd0, 0, 32'h0);
        step(1, 2'd0, 5'd6, 32'h22, 32'h0, 3'd0, 0, 32'h0);
        step(1, 2'd0, 5'd7, 32'h33, 32'h0, 3'd0, 0, 32'h0);
        check_eq("b2b_data3", data_o, 32'h33);
        check_eq("b2b_instret", instret_o, 64'd3);
        step(0, 2'd0, 5'd0, 32'h0, 32'h0, 3'd0, 0, 32'h0);

        // lb sign extension with a 4-cycle memory delay
        step(1, 2'd1, 5'd9, 32'h0000_1003, 32'h0, 3'd0, 0, 32'h0);
        step(0, 2'd0, 5'd0, 32'h0, 32'h0, 3'd0, 0, 32'h0);
        step(0, 2'd0, 5'd0, 32'h0, 32'h0, 3'd0, 0, 32'h0);
        step(0, 2'd0, 5'd0, 32'h0, 32'h0, 3'd0, 0, 32'h0);
        step(0, 2'd0, 5'd0, 32'h0, 32'h0, 3'd0, 1, 32'h80FF_FF7F);
        check_eq("lb_data", data_o, 32'hFFFF_FF80);
        check_eq("lb_wen", wen_o, 1);

        // lhu upper half
        step(1, 2'd1, 5'd10, 32'h0000_4002, 32'h0, 3'd5, 0, 32'h0);
        step(0, 2'd0, 5'd0, 32'h0, 32'h0, 3'd0, 1, 32'hBEEF_1234);
        check_eq("lhu_data", data_o, 32'h0000_BEEF);

        // misaligned lw
        ret_save = e_ret;
        step(1, 2'd1, 5'd11, 32'h0000_5001, 32'h0, 3'd2, 0, 32'h0);
        step(0, 2'd0, 5'd0, 32'h0, 32'h0, 3'd0, 1, 32'h1234_5678);
        check_eq("mis_err", err_o, 1);
        check_eq("mis_wen", wen_o, 0);
        check_eq("mis_instret", instret_o, ret_save);
        step(0, 2'd0, 5'd0, 32'h0, 32'h0, 3'd0, 0, 32'h0);
        check_eq("mis_err_clear", err_o, 0);

        // rd=0 and store, with the counter preloaded just below wrap
        force dut.instret_q = 64'hFFFF_FFFF_FFFF_FFFE;
        #1;
        release dut.instret_q;
        e_ret = 64'hFFFF_FFFF_FFFF_FFFE;
        step(1, 2'd0, 5'd0, 32'hABCD, 32'h0, 3'd0, 0, 32'h0);
        step(1, 2'd3, 5'd12, 32'h1234, 32'h0, 3'd0, 0, 32'h0);
        check_eq("wrap_instret", instret_o, 64'd0);
        check_eq("store_wen", wen_o, 0);
        step(0, 2'd0, 5'd0, 32'h0, 32'h0, 3'd0, 0, 32'h0);

        // random traffic
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 99) < 65,
                 2'($urandom_range(0, 3)),
                 5'($urandom_range(0, 31)),
                 $urandom(),
                 $urandom(),
                 3'($urandom_range(0, 7)),
                 $urandom_range(0, 99) < 40,
                 $urandom());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
